// File: rtl/vedic_pkg.sv
// vedic_pkg: shared state encoding and sizing for the sequential Vedic multiplier.
package vedic_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int W_DEF = 8;
  function automatic int digits_of(input int w);
    return w / 2;
  endfunction
  localparam int N = digits_of(W_DEF);
  localparam int CYCLES = N * N;
endpackage

// File: rtl/vedic2x2.sv
// vedic2x2: combinational 2x2-bit Urdhva-Tiryagbhyam multiplier.
module vedic2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] y
);
  logic c1;
  always_comb begin
    c1   = a[1] & b[0] & a[0] & b[1];
    y[0] = a[0] & b[0];
    y[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    y[2] = (a[1] & b[1]) ^ c1;
    y[3] = a[1] & b[1] & c1;
  end
endmodule

// File: rtl/vedic_seq_mul8.sv
// vedic_seq_mul8: unsigned WxW multiplier that reuses one 2x2 Vedic cell over
// all digit pairs, one pair per cycle, accumulating shifted partial products.
module vedic_seq_mul8
  import vedic_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] y
);
  localparam int ND = digits_of(W);
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  state_t         state_q;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] acc_q, acc_d, y_q;
  logic [CW-1:0]  i_q, j_q;
  logic           busy_q, done_q;
  logic [1:0]     da, db;
  logic [3:0]     pp;
  logic           j_last, last;
  vedic2x2 u_cell (.a(da), .b(db), .y(pp));
  always_comb begin
    da     = a_q[2*int'(i_q) +: 2];
    db     = b_q[2*int'(j_q) +: 2];
    acc_d  = acc_q + ((2*W)'(pp) << (2 * (int'(i_q) + int'(j_q))));
    j_last = j_q == CW'(ND - 1);
    last   = j_last && (i_q == CW'(ND - 1));
  end
  // y is only written when leaving RUN, so partial sums never reach the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          a_q     <= a;
          b_q     <= b;
          acc_q   <= '0;
          i_q     <= '0;
          j_q     <= '0;
          busy_q  <= 1'b1;
        end
        RUN: begin
          acc_q <= acc_d;
          j_q   <= j_last ? '0 : j_q + CW'(1);
          i_q   <= j_last ? i_q + CW'(1) : i_q;
          if (last) begin
            state_q <= DONE;
            y_q     <= acc_d;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;
endmodule

// File: tb/tb_vedic_seq_mul8.sv
// tb_vedic_seq_mul8: directed vector table, multi-cycle corner sequences and a
// random sweep against the native product, all sampled on the falling edge.
module tb_vedic_seq_mul8;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] y;
  int          checks = 0;
  int          errors = 0;

  vedic_seq_mul8 #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns after it is idle again.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int bcnt, output int dcnt,
                        output logic [15:0] yv);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    lat = -1; bcnt = 0; dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) bcnt++;
      if (done) dcnt++;
      if (done && lat < 0) lat = k;
      if (!busy && k > 0) break;
      @(negedge clk);
    end
    yv = y;
  endtask

  initial begin
    vec_t        vecs[9];
    int          lat, bcnt, dcnt, n_done, last_n;
    logic [15:0] yv, exp_y;
    logic [7:0]  ra, rb;
    vecs[0] = '{8'hA5, 8'h3C, 16'h26AC};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'h7E, 16'h0000};
    vecs[3] = '{8'h01, 8'h80, 16'h0080};
    vecs[4] = '{8'h03, 8'h05, 16'h000F};
    vecs[5] = '{8'h12, 8'h34, 16'h03A8};
    vecs[6] = '{8'h80, 8'h80, 16'h4000};
    vecs[7] = '{8'hAA, 8'h55, 16'h3872};
    vecs[8] = '{8'h7F, 8'h02, 16'h00FE};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_y", 32'(y), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      run_op(vecs[v].a, vecs[v].b, lat, bcnt, dcnt, yv);
      chk($sformatf("vec%0d_y", v), 32'(yv), 32'(vecs[v].y));
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd16);
      chk($sformatf("vec%0d_busy_cycles", v), 32'(bcnt), 32'd17);
      chk($sformatf("vec%0d_done_pulses", v), 32'(dcnt), 32'd1);
    end

    // start pulsed during RUN must be ignored and not queued
    a = 8'hA5; b = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (k == 4) begin a = 8'h11; b = 8'h11; start = 1'b1; end
      if (k == 5) start = 1'b0;
      if (done && lat < 0) lat = k;
      if (!busy && k > 0) break;
      @(negedge clk);
    end
    chk("ignored_start_latency", 32'(lat), 32'd16);
    chk("ignored_start_y", 32'(y), 32'h26AC);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("ignored_start_not_queued", 32'(busy), 32'h0);

    // asynchronous reset in the middle of RUN aborts the operation
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_y", 32'(y), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0; bcnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'h0);
    chk("abort_stays_idle", 32'(bcnt), 32'h0);
    chk("abort_y_stays_zero", 32'(y), 32'h0);

    // start accepted on the first rising edge after reset release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h12, 8'h34, lat, bcnt, dcnt, yv);
    chk("post_reset_latency", 32'(lat), 32'd16);
    chk("post_reset_y", 32'(yv), 32'h03A8);

    // held-high start: one result every 18 cycles
    a = 8'h03; b = 8'h05; start = 1'b1;
    n_done = 0; last_n = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        chk("held_y", 32'(y), 32'h000F);
        chk("held_spacing", 32'(n - last_n), (last_n < 0) ? 32'd17 : 32'd18);
        last_n = n;
      end
    end
    chk("held_done_count", 32'(n_done), 32'd3);
    start = 1'b0;
    for (int k = 0; k < 30 && busy; k++) @(negedge clk);
    chk("held_drained", 32'(busy), 32'h0);

    for (int r = 0; r < 1000; r++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      exp_y = 16'(ra) * 16'(rb);
      run_op(ra, rb, lat, bcnt, dcnt, yv);
      chk($sformatf("rand%0d_%0h_x_%0h", r, ra, rb), 32'(yv), 32'(exp_y));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vedic_seq_mul8.md
VEDIC_SEQ_MUL8 -- requirements
Module: vedic_seq_mul8

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to multiply the current a and b.
REQ-005 SHALL have port a, input, W bits: unsigned multiplicand, sampled only on the accepted start.
REQ-006 SHALL have port b, input, W bits: unsigned multiplier, sampled only on the accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress (RUN or DONE).
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port y, output, 2W bits: registered product of the last completed operation.

Function
REQ-010 SHALL compute y = a*b (unsigned) by iterating one combinational 2x2 multiplier over all N*N digit pairs, where N = W/2.
REQ-011 SHALL implement the states IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after the last digit pair.
- DONE -> IDLE unconditionally.
REQ-012 SHALL accept start only in IDLE; start in RUN or DONE is ignored, and no request is queued.
REQ-013 SHALL, on accept, do the following:
- register a into a_r and b into b_r;
- clear the 2W-bit accumulator;
- clear digit counters i and j.
REQ-014 SHALL, in each RUN cycle, add pp(i,j) = a_r[2i+1:2i] * b_r[2j+1:2j] (4 bits), shifted left by 2*(i+j), to the accumulator, modulo 2^(2W).
REQ-015 SHALL step j from 0 to N-1, then wrap j to 0 and increment i; the final pair is i = j = N-1.
REQ-016 SHALL load y with the final accumulator value (including the last pp) on the edge leaving RUN.
REQ-017 SHALL give the following timing:
- RUN lasts exactly N*N cycles (16 for W=8);
- done is high for exactly the one cycle spent in DONE, which begins N*N edges after the accepting edge.
REQ-018 SHALL hold y stable from one completion until the next completion; y never shows partial sums.
REQ-019 SHALL allow a held-high start to begin a new operation every N*N+2 cycles (the accept edge, N*N RUN edges and one DONE edge).
REQ-020 SHALL give results unaffected by a and b changing after acceptance.

Reset
REQ-021 SHALL, on rst_n=0 at any time (including mid-RUN), immediately force all of the following:
- state = IDLE;
- busy = 0, done = 0, y = 0;
- accumulator, i, j, a_r and b_r = 0.
REQ-022 SHALL, after rst_n deasserts, accept start from the first rising edge; no result of an aborted operation ever appears on y.

Structure
REQ-023 SHALL take the state enumeration, W default, N and the constant CYCLES = N*N from shared package vedic_pkg.
REQ-024 SHALL instantiate exactly one sub-module, vedic2x2: combinational, 2-bit a and b, 4-bit y.
REQ-025 SHALL keep all arithmetic other than the 2x2 product (shift, accumulate) in vedic_seq_mul8.

Verification
REQ-026 SHALL cover: reset, then a=8'hA5, b=8'h3C, start pulsed one cycle -> busy high for 17 cycles, done pulses once 16 edges after accept, y=16'h26AC.
REQ-027 SHALL cover: a=8'hFF, b=8'hFF -> y=16'hFE01; a=8'h00, b=8'h7E -> y=16'h0000; a=8'h01, b=8'h80 -> y=16'h0080.
REQ-028 SHALL cover: start pulsed at RUN cycle 5 with a=8'h11, b=8'h11 -> ignored; the first result still completes at the original time with the original operands.
REQ-029 SHALL cover: rst_n low for one cycle at RUN cycle 8 -> y=0, busy=0, done=0 immediately; no done pulse follows.
REQ-030 SHALL cover: start held high with a=8'h03, b=8'h05 -> done every 18 cycles, y=16'h000F each time.
REQ-031 SHALL cover: 1000 random operand pairs compared against a reference product; zero mismatches allowed.
